// File: rtl/jk_counter_pkg.sv
// -----------------------------------------------------------------------------
// jk_counter_pkg
//   Shared definitions for the JK-cell based synchronous counter.
//   - JK_* : two-bit {j,k} excitation codes understood by jk_cell.
//   - jk_excite(q, d) : toggle-form excitation that moves a cell from its
//     present state q to the wanted next state d.
//
//   The excitation is always either hold (00) or toggle (11). The clear and set
//   codes exist so that the cell's full truth table can be named, but the
//   counter never drives them.
// -----------------------------------------------------------------------------
package jk_counter_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   // Toggle form: flip the cell when present and next state differ,
   // otherwise leave it alone. The result is {j, k}.
   function automatic logic [1:0] jk_excite(input logic q, input logic d);
      logic [1:0] jk;
      jk = (q ^ d) ? JK_TOG : JK_HOLD;
      return jk;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
//   One-bit JK storage cell with synchronous active-high reset.
//
//   Ports
//     clock  in  1  rising-edge clock
//     reset  in  1  synchronous, active-high; forces q to 0
//     j      in  1  J excitation
//     k      in  1  K excitation
//     q      out 1  stored bit
//
//   Cell rule on each rising edge (when not in reset):
//     JK=00 hold, 01 clear, 10 set, 11 toggle.
// -----------------------------------------------------------------------------
module jk_cell
   import jk_counter_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            JK_HOLD: q <= q;
            JK_CLR:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/jk_sync_counter.sv
// -----------------------------------------------------------------------------
// jk_sync_counter
//   Synchronous modulo-MODULUS up/down counter whose state lives in a bank of
//   JK cells. Each cycle the next count D is computed, turned into per-bit
//   toggle-form J/K excitation, and the cells are clocked. The J/K vectors are
//   exported so this block can drive a downstream JK flip-flop stage, and tc
//   allows several counters to be cascaded as a divider chain.
//
//   Parameters
//     WIDTH    bits of count state (MODULUS must be <= 2**WIDTH)
//     MODULUS  sequence length, counts 0..MODULUS-1 (must be >= 2)
//
//   Ports
//     clock     in   1      rising-edge clock
//     reset     in   1      synchronous, active-high; count -> 0
//     enable    in   1      advance one step this cycle
//     up_dn     in   1      1 = count up, 0 = count down
//     load      in   1      load load_val this cycle (beats enable)
//     load_val  in   WIDTH  value to load, saturated to MODULUS-1
//     count     out  WIDTH  current count (cell Q outputs)
//     j_vec     out  WIDTH  per-bit J excitation driving the cells
//     k_vec     out  WIDTH  per-bit K excitation driving the cells
//     tc        out  1      terminal count, high in the cycle whose edge wraps
//
//   Priority at each edge: reset > load > enable > hold.
// -----------------------------------------------------------------------------
module jk_sync_counter
   import jk_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec,
   output logic             tc
);

   // Parameter sanity: a modulus below 2 is not a counter, and one above
   // 2**WIDTH cannot be represented in the cells.
   generate
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("jk_sync_counter: MODULUS=%0d invalid for WIDTH=%0d",
                MODULUS, WIDTH);
      end
   endgenerate

   // Arithmetic is carried one bit wider than the count so that count+1 at
   // the top of a full-range (MODULUS == 2**WIDTH) counter cannot alias to 0
   // before the wrap comparison, and the load saturation compare is unsigned.
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   load_ext;
   logic [WIDTH:0]   inc_ext;
   logic [WIDTH:0]   dec_ext;
   logic [WIDTH:0]   d_ext;
   logic [WIDTH-1:0] next_count;
   logic [1:0]       jk;
   logic             at_top;
   logic             at_bottom;

   // Next-count selection.
   always_comb begin
      cnt_ext  = {1'b0, count};
      load_ext = {1'b0, load_val};
      inc_ext  = cnt_ext + 1'b1;
      dec_ext  = cnt_ext - 1'b1;
      at_top    = (cnt_ext == MAX_EXT);
      at_bottom = (cnt_ext == '0);
      d_ext     = cnt_ext;

      if (load) begin
         d_ext = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
      end else if (enable) begin
         if (up_dn) begin
            d_ext = at_top ? '0 : inc_ext;
         end else begin
            d_ext = at_bottom ? MAX_EXT : dec_ext;
         end
      end

      next_count = d_ext[WIDTH-1:0];
   end

   // Per-bit toggle-form excitation. Reset is deliberately not folded in:
   // the cells clear themselves on reset, so j/k keep showing the D the
   // inputs would otherwise produce.
   always_comb begin
      j_vec = '0;
      k_vec = '0;
      jk    = JK_HOLD;
      for (int i = 0; i < WIDTH; i++) begin
         jk       = jk_excite(count[i], next_count[i]);
         j_vec[i] = jk[1];
         k_vec[i] = jk[0];
      end
   end

   // Carry-out for cascading: asserted only when this edge will wrap.
   always_comb begin
      tc = enable & ~load & ((up_dn & at_top) | (~up_dn & at_bottom));
   end

   // Storage: one JK cell per count bit.
   generate
      for (genvar g = 0; g < WIDTH; g++) begin : g_cell
         jk_cell u_cell (
            .clock (clock),
            .reset (reset),
            .j     (j_vec[g]),
            .k     (k_vec[g]),
            .q     (count[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_jk_sync_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_sync_counter
//   Directed and randomised checks of jk_sync_counter with WIDTH=4, MODULUS=10.
// -----------------------------------------------------------------------------
module tb_jk_sync_counter;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic [3:0] j_vec;
   logic [3:0] k_vec;
   logic       tc;

   int checks;
   int failures;

   jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .j_vec    (j_vec),
      .k_vec    (k_vec),
      .tc       (tc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Independent reference for the next count.
   function automatic int model_next(input int c, input bit rst, input bit ld,
                                     input int lv, input bit en, input bit up);
      if (rst)     return 0;
      if (ld)      return (lv > 9) ? 9 : lv;
      if (!en)     return c;
      if (up)      return (c + 1) % 10;
      return (c + 9) % 10;
   endfunction

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
      tick();
      reset = 1'b0; enable = 1'b0; load = 1'b0; load_val = 4'd0;
      #1;
      checks++;
      if (count !== 4'd0) begin
         failures++;
         $display("FAIL reset_count: got %0d expected 0", count);
      end
      checks++;
      if (tc !== 1'b0) begin
         failures++;
         $display("FAIL reset_tc: got %0b expected 0", tc);
      end
   endtask

   task automatic test_count_up();
      enable = 1'b1; up_dn = 1'b1; load = 1'b0;
      #1;
      for (int e = 0; e < 12; e++) begin
         checks++;
         if (count !== 4'(e % 10)) begin
            failures++;
            $display("FAIL up_count[%0d]: got %0d expected %0d", e, count, e % 10);
         end
         checks++;
         if (tc !== ((e % 10) == 9)) begin
            failures++;
            $display("FAIL up_tc[%0d]: got %0b expected %0b", e, tc, (e % 10) == 9);
         end
         tick();
      end
      checks++;
      if (count !== 4'd2) begin
         failures++;
         $display("FAIL up_final: got %0d expected 2", count);
      end
   endtask

   task automatic test_wrap_down();
      reset = 1'b1; enable = 1'b0;
      tick();
      reset = 1'b0; enable = 1'b1; up_dn = 1'b0; load = 1'b0;
      #1;
      checks++;
      if (tc !== 1'b1) begin
         failures++;
         $display("FAIL down_tc: got %0b expected 1", tc);
      end
      checks++;
      if (j_vec !== 4'b1001) begin
         failures++;
         $display("FAIL down_j: got %b expected 1001", j_vec);
      end
      checks++;
      if (k_vec !== 4'b1001) begin
         failures++;
         $display("FAIL down_k: got %b expected 1001", k_vec);
      end
      tick();
      checks++;
      if (count !== 4'd9) begin
         failures++;
         $display("FAIL down_wrap: got %0d expected 9", count);
      end
      // One more step down: 9 -> 8, no terminal count on the way.
      checks++;
      if (tc !== 1'b0) begin
         failures++;
         $display("FAIL down_tc9: got %0b expected 0", tc);
      end
      tick();
      checks++;
      if (count !== 4'd8) begin
         failures++;
         $display("FAIL down_step: got %0d expected 8", count);
      end
   endtask

   task automatic test_load();
      enable = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd13;
      tick();
      checks++;
      if (count !== 4'd9) begin
         failures++;
         $display("FAIL load_sat: got %0d expected 9", count);
      end
      // count is 9 counting up, but a load masks the terminal count.
      load_val = 4'd5;
      #1;
      checks++;
      if (tc !== 1'b0) begin
         failures++;
         $display("FAIL load_tc_mask: got %0b expected 0", tc);
      end
      tick();
      checks++;
      if (count !== 4'd5) begin
         failures++;
         $display("FAIL load_5: got %0d expected 5", count);
      end
      load = 1'b0; enable = 1'b0;
   endtask

   task automatic test_reset_priority();
      load = 1'b1; load_val = 4'd7; enable = 1'b0;
      tick();
      checks++;
      if (count !== 4'd7) begin
         failures++;
         $display("FAIL prio_setup: got %0d expected 7", count);
      end
      reset = 1'b1; load = 1'b1; load_val = 4'd3; enable = 1'b1; up_dn = 1'b1;
      tick();
      checks++;
      if (count !== 4'd0) begin
         failures++;
         $display("FAIL prio_reset: got %0d expected 0", count);
      end
      reset = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   task automatic test_hold();
      load = 1'b1; load_val = 4'd6;
      tick();
      load = 1'b0; enable = 1'b0; up_dn = 1'b1;
      for (int e = 0; e < 5; e++) begin
         #1;
         checks++;
         if (j_vec !== 4'd0 || k_vec !== 4'd0) begin
            failures++;
            $display("FAIL hold_jk[%0d]: got j=%b k=%b expected 0000", e, j_vec, k_vec);
         end
         checks++;
         if (tc !== 1'b0) begin
            failures++;
            $display("FAIL hold_tc[%0d]: got %0b expected 0", e, tc);
         end
         tick();
         checks++;
         if (count !== 4'd6) begin
            failures++;
            $display("FAIL hold_count[%0d]: got %0d expected 6", e, count);
         end
      end
   endtask

   task automatic test_random();
      int  ref_cnt;
      int  nxt;
      bit  exp_tc;
      logic [3:0] exp_jk;
      reset = 1'b1; load = 1'b0; enable = 1'b0;
      tick();
      ref_cnt = 0;
      for (int n = 0; n < 2000; n++) begin
         reset    = ($urandom_range(0, 49) == 0);
         load     = ($urandom_range(0, 9) == 0);
         enable   = ($urandom_range(0, 3) != 0);
         up_dn    = $urandom_range(0, 1);
         load_val = 4'($urandom_range(0, 15));
         #1;
         nxt    = model_next(ref_cnt, reset, load, int'(load_val), enable, up_dn);
         exp_jk = 4'(ref_cnt) ^ 4'(model_next(ref_cnt, 1'b0, load, int'(load_val),
                                                enable, up_dn));
         exp_tc = enable && !load && ((up_dn && ref_cnt == 9) || (!up_dn && ref_cnt == 0));
         checks++;
         if (j_vec !== k_vec || j_vec !== exp_jk) begin
            failures++;
            $display("FAIL rnd_jk[%0d]: got j=%b k=%b expected %b", n, j_vec, k_vec, exp_jk);
         end
         checks++;
         if (tc !== exp_tc) begin
            failures++;
            $display("FAIL rnd_tc[%0d]: got %0b expected %0b", n, tc, exp_tc);
         end
         tick();
         ref_cnt = nxt;
         checks++;
         if (count !== 4'(ref_cnt) || count >= 4'd10) begin
            failures++;
            $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, count, ref_cnt);
         end
      end
      reset = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      enable   = 1'b0;
      up_dn    = 1'b1;
      load     = 1'b0;
      load_val = 4'd0;
      test_reset();
      test_count_up();
      test_wrap_down();
      test_load();
      test_reset_priority();
      test_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
